// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray-code helpers and default sizing
//
// Purpose: Gray/binary conversion functions and default counter
//          geometry shared by the Gray counter and its consumers.
// Contents:
//   GRAY_WIDTH_DEFAULT     default count width (4 bits for a 16-state counter)
//   GRAY_MAX_COUNT_DEFAULT default terminal count of the upstream counter
//   gray2bin(g)            Gray -> binary, any width up to 32 (zero-extend input)
//   bin2gray(b)            binary -> Gray, any width up to 32 (zero-extend input)
// Optional feature macro used by consumers: GRAY_SYNC_ERRCNT_EN

package gray_pkg;

  localparam int GRAY_WIDTH_DEFAULT     = 4;
  localparam int GRAY_MAX_COUNT_DEFAULT = 15;

  // Zero bits above the real width decode to zero, so a zero-extended
  // operand yields the correct narrow result in the low bits.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - generic N-stage, W-bit flop synchronizer
//
// Purpose: plain flop chain for clock-domain crossing; no logic between
//          stages so every stage after the first sees a settled value.
// Ports:
//   clk      in  1  destination clock, rising edge
//   reset_n  in  1  synchronous active-low reset, clears every stage
//   d        in  W  asynchronous input
//   q        out W  output of the last stage

module sync_chain #(
  parameter int STAGES = 2,
  parameter int W      = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// rtl/gray_sync_decoder.sv - synchronize, decode and step-check a Gray count
//
// Purpose: brings a Gray count from a foreign timing context through a
//          flop synchronizer, registers its binary decode and flags every
//          change that is not +1 or the MAX_COUNT->0 wrap.
// Ports:
//   clk         in  1      sole clock, rising edge
//   reset_n     in  1      synchronous active-low reset
//   gray_in     in  WIDTH  Gray-coded count, asynchronous to clk
//   err_clr     in  1      clears sticky err (level-sampled)
//   binary_out  out WIDTH  registered binary decode of the synchronized value
//   valid       out 1      synchronizer pipeline has filled since reset
//   step        out 1      pulse: binary_out advanced by one (incl. wrap)
//   wrap        out 1      pulse: binary_out went MAX_COUNT->0
//   err         out 1      sticky illegal-transition flag
//   err_count   out 8      saturating illegal-transition count
//                          (present only with GRAY_SYNC_ERRCNT_EN defined)

module gray_sync_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH       = GRAY_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_COUNT   = GRAY_MAX_COUNT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] binary_out,
  output logic             valid,
  output logic             step,
  output logic             wrap,
  output logic             err
`ifdef GRAY_SYNC_ERRCNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam logic [WIDTH:0] MAX_V     = (WIDTH+1)'(MAX_COUNT);
  localparam logic [2:0]     FILL_DONE = 3'(SYNC_STAGES);

  logic [WIDTH-1:0] gray_sync;
  logic [WIDTH-1:0] dec;
  logic [WIDTH:0]   old_ext;
  logic [WIDTH:0]   new_ext;
  logic [2:0]       fill_cnt;
  logic             is_same;
  logic             is_step;
  logic             is_wrap;
  logic             over_max;
  logic             illegal;

  sync_chain #(
    .STAGES (SYNC_STAGES),
    .W      (WIDTH)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (gray_in),
    .q       (gray_sync)
  );

  assign dec = WIDTH'(gray2bin(32'(gray_sync)));

  // Compare one bit wider so old+1 at the top of the range cannot alias to 0.
  always_comb begin
    old_ext  = {1'b0, binary_out};
    new_ext  = {1'b0, dec};
    is_same  = (new_ext == old_ext);
    is_step  = (old_ext < MAX_V) && (new_ext == old_ext + (WIDTH+1)'(1));
    is_wrap  = (old_ext == MAX_V) && (new_ext == '0);
    over_max = (new_ext > MAX_V);
    illegal  = over_max || !(is_same || is_step || is_wrap);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fill_cnt   <= '0;
      valid      <= 1'b0;
      binary_out <= '0;
      step       <= 1'b0;
      wrap       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // binary_out tracks the decode even during fill, so the first checked
      // edge compares two values that both came through the synchronizer.
      binary_out <= dec;
      if (fill_cnt != FILL_DONE) begin
        fill_cnt <= fill_cnt + 3'd1;
      end
      if (fill_cnt == FILL_DONE) begin
        valid <= 1'b1;
      end
      step <= valid && (is_step || is_wrap);
      wrap <= valid && is_wrap;
      // Set wins over clear on the same edge.
      if (valid && illegal) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

`ifdef GRAY_SYNC_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (valid && illegal) begin
      if (err_clr) begin
        err_count <= 8'd1;
      end else if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end else if (err_clr) begin
      err_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// tb/tb_gray_sync_decoder.sv - self-checking bench for gray_sync_decoder

module tb_gray_sync_decoder;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk;
  logic         reset_n;
  logic         err_clr;
  logic [W-1:0] gray_a, gray_b;
  logic [W-1:0] bin_a, bin_b;
  logic         valid_a, valid_b, step_a, step_b, wrap_a, wrap_b, err_a, err_b;
`ifdef GRAY_SYNC_ERRCNT_EN
  logic [7:0]   cnt_a, cnt_b;
`endif

  gray_sync_decoder #(.WIDTH(W), .SYNC_STAGES(S), .MAX_COUNT(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .gray_in    (gray_a),
    .err_clr    (err_clr),
    .binary_out (bin_a),
    .valid      (valid_a),
    .step       (step_a),
    .wrap       (wrap_a),
    .err        (err_a)
`ifdef GRAY_SYNC_ERRCNT_EN
    ,
    .err_count  (cnt_a)
`endif
  );

  gray_sync_decoder #(.WIDTH(W), .SYNC_STAGES(S), .MAX_COUNT(9)) dut9 (
    .clk        (clk),
    .reset_n    (reset_n),
    .gray_in    (gray_b),
    .err_clr    (err_clr),
    .binary_out (bin_b),
    .valid      (valid_b),
    .step       (step_b),
    .wrap       (wrap_b),
    .err        (err_b)
`ifdef GRAY_SYNC_ERRCNT_EN
    ,
    .err_count  (cnt_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int step_cnt_a, step_cnt_b, wrap_cnt_a, wrap_cnt_b;
  int gray_tab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  // Reference model state, one slot per instance (0: MAX 15, 1: MAX 9).
  int m_pipe [2][S];
  int m_bin [2];
  int m_fill [2];
  int m_cnt [2];
  bit m_valid [2];
  bit m_step [2];
  bit m_wrap [2];
  bit m_err [2];

  function automatic int maxc(input int i);
    return (i == 0) ? 15 : 9;
  endfunction

  // Decode by searching for the binary value whose Gray image matches.
  function automatic int ref_decode(input int g);
    for (int b = 0; b < (1 << W); b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i, input logic rst, input int g, input logic clr);
    int nv, ov, mx;
    bit ill;
    if (!rst) begin
      for (int k = 0; k < S; k++) m_pipe[i][k] = 0;
      m_bin[i] = 0; m_fill[i] = 0; m_cnt[i] = 0;
      m_valid[i] = 0; m_step[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
      return;
    end
    nv = ref_decode(m_pipe[i][S-1]);
    ov = m_bin[i];
    mx = maxc(i);
    m_step[i] = 0;
    m_wrap[i] = 0;
    ill = 0;
    if (m_valid[i]) begin
      if (nv > mx) ill = 1;
      else if (nv == ov) begin end
      else if (ov < mx && nv == ov + 1) m_step[i] = 1;
      else if (ov == mx && nv == 0) begin m_step[i] = 1; m_wrap[i] = 1; end
      else ill = 1;
    end
    if (ill) begin
      m_err[i] = 1;
      m_cnt[i] = clr ? 1 : ((m_cnt[i] < 255) ? m_cnt[i] + 1 : 255);
    end else if (clr) begin
      m_err[i] = 0;
      m_cnt[i] = 0;
    end
    m_bin[i] = nv;
    for (int k = S - 1; k > 0; k--) m_pipe[i][k] = m_pipe[i][k-1];
    m_pipe[i][0] = g;
    m_fill[i]++;
    m_valid[i] = (m_fill[i] >= S + 1);
  endtask

  task automatic tick(input logic rst, input int ga, input int gb, input logic clr);
    reset_n = rst;
    gray_a  = ga[W-1:0];
    gray_b  = gb[W-1:0];
    err_clr = clr;
    @(posedge clk);
    model_step(0, rst, ga, clr);
    model_step(1, rst, gb, clr);
    #1;
    check("a_bin", 32'(bin_a), 32'(m_bin[0]));
    check("a_valid", 32'(valid_a), 32'(m_valid[0]));
    check("a_step", 32'(step_a), 32'(m_step[0]));
    check("a_wrap", 32'(wrap_a), 32'(m_wrap[0]));
    check("a_err", 32'(err_a), 32'(m_err[0]));
    check("b_bin", 32'(bin_b), 32'(m_bin[1]));
    check("b_valid", 32'(valid_b), 32'(m_valid[1]));
    check("b_step", 32'(step_b), 32'(m_step[1]));
    check("b_wrap", 32'(wrap_b), 32'(m_wrap[1]));
    check("b_err", 32'(err_b), 32'(m_err[1]));
`ifdef GRAY_SYNC_ERRCNT_EN
    check("a_err_count", 32'(cnt_a), 32'(m_cnt[0]));
    check("b_err_count", 32'(cnt_b), 32'(m_cnt[1]));
`endif
    if (step_a === 1'b1) step_cnt_a++;
    if (step_b === 1'b1) step_cnt_b++;
    if (wrap_a === 1'b1) wrap_cnt_a++;
    if (wrap_b === 1'b1) wrap_cnt_b++;
  endtask

  initial begin
    int cur_a, cur_b, r;
    reset_n = 1'b0; err_clr = 1'b0; gray_a = '0; gray_b = '0;

    // Reset and fill
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 0, 1'b0);
    tick(1'b1, 0, 0, 1'b0); check("fill_e1_valid", 32'(valid_a), 32'd0);
    tick(1'b1, 0, 0, 1'b0); check("fill_e2_valid", 32'(valid_a), 32'd0);
    tick(1'b1, 0, 0, 1'b0); check("fill_e3_valid", 32'(valid_a), 32'd1);
    check("fill_bin", 32'(bin_a), 32'd0);

    // Full sweep on MAX 15, 0..9 sweep with wrap on MAX 9
    step_cnt_a = 0; step_cnt_b = 0; wrap_cnt_a = 0; wrap_cnt_b = 0;
    for (int v = 1; v <= 16; v++)
      for (int k = 0; k < 4; k++) tick(1'b1, gray_tab[v % 16], gray_tab[v % 10], 1'b0);
    check("sweep_steps_a", 32'(step_cnt_a), 32'd16);
    check("sweep_wraps_a", 32'(wrap_cnt_a), 32'd1);
    check("sweep_steps_b", 32'(step_cnt_b), 32'd16);
    check("sweep_wraps_b", 32'(wrap_cnt_b), 32'd1);
    check("sweep_err_a", 32'(err_a), 32'd0);
    check("sweep_err_b", 32'(err_b), 32'd0);

    // Illegal jump 3 -> 7, then clear
    for (int v = 1; v <= 3; v++)
      for (int k = 0; k < 4; k++) tick(1'b1, gray_tab[v], gray_tab[6], 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b1, gray_tab[7], gray_tab[6], 1'b0);
    check("jump_err", 32'(err_a), 32'd1);
    check("jump_bin", 32'(bin_a), 32'd7);
    check("jump_step", 32'(step_a), 32'd0);
    tick(1'b1, gray_tab[7], gray_tab[6], 1'b0);
    check("jump_sticky", 32'(err_a), 32'd1);
    tick(1'b1, gray_tab[7], gray_tab[6], 1'b1);
    check("jump_clr", 32'(err_a), 32'd0);

    // Clear coinciding with a fresh illegal jump 7 -> 2
    for (int k = 0; k < 4; k++) tick(1'b1, gray_tab[12], gray_tab[6], 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b1, gray_tab[7], gray_tab[6], 1'b0);
    tick(1'b1, gray_tab[2], gray_tab[6], 1'b0);
    tick(1'b1, gray_tab[2], gray_tab[6], 1'b0);
    tick(1'b1, gray_tab[2], gray_tab[6], 1'b1);
    check("setwins_err", 32'(err_a), 32'd1);
    check("setwins_bin", 32'(bin_a), 32'd2);
`ifdef GRAY_SYNC_ERRCNT_EN
    check("setwins_count", 32'(cnt_a), 32'd1);
`endif
    tick(1'b1, gray_tab[2], gray_tab[6], 1'b1);
    check("setwins_clr", 32'(err_a), 32'd0);

    // Reset mid-sweep at 6
    for (int v = 3; v <= 6; v++)
      for (int k = 0; k < 4; k++) tick(1'b1, gray_tab[v], gray_tab[6], 1'b0);
    check("mid_bin_before", 32'(bin_a), 32'd6);
    tick(1'b0, gray_tab[6], gray_tab[6], 1'b0);
    check("mid_rst_bin", 32'(bin_a), 32'd0);
    check("mid_rst_valid", 32'(valid_a), 32'd0);
    tick(1'b1, gray_tab[6], gray_tab[6], 1'b0); check("mid_e1_valid", 32'(valid_a), 32'd0);
    tick(1'b1, gray_tab[6], gray_tab[6], 1'b0); check("mid_e2_valid", 32'(valid_a), 32'd0);
    tick(1'b1, gray_tab[6], gray_tab[6], 1'b0); check("mid_e3_valid", 32'(valid_a), 32'd1);
    check("mid_e3_bin", 32'(bin_a), 32'd6);
    for (int k = 0; k < 3; k++) tick(1'b1, gray_tab[6], gray_tab[6], 1'b0);
    check("mid_no_err", 32'(err_a), 32'd0);

    // Randomized traffic: mostly legal steps, some holds, some wild jumps
    cur_a = 6; cur_b = 6;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 6) cur_a = (cur_a >= 15) ? 0 : cur_a + 1;
        else if (r >= 8) cur_a = $urandom_range(0, 15);
      end
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 6) cur_b = (cur_b >= 9) ? 0 : cur_b + 1;
        else if (r >= 8) cur_b = $urandom_range(0, 15);
      end
      tick(1'b1, gray_tab[cur_a], gray_tab[cur_b], ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gray_sync_decoder.md
Name: gray_sync_decoder

Overview:
Downstream consumer of the Gray counter. It takes a Gray-coded count that arrives from a free-running counter in another timing context and passes it through a multi-flop synchronizer. It then decodes the value to binary and checks that every observed change is a legal single step, either +1 or the wrap to 0. Typical sink is a FIFO pointer comparator or an event-rate monitor that needs a clean binary count plus step/wrap strobes.

Parameters:
WIDTH, 4, bit width of gray_in/binary_out (matches counter SIZE=16 → 4 bits)
SYNC_STAGES, 2, synchronizer depth; legal range 2..4
MAX_COUNT, 15, terminal count of the upstream counter; wrap is MAX_COUNT→0; must be ≤ 2^WIDTH-1

Ports:
clk  in  1  sole clock, rising edge
reset_n  in  1  synchronous active-low reset, sampled on rising clk
gray_in  in  WIDTH  Gray-coded count from upstream counter (asynchronous to clk)
err_clr  in  1  clears sticky err; level-sampled
binary_out  out  WIDTH  registered binary decode of synchronized Gray value
valid  out  1  high once the synchronizer pipeline has filled after reset
step  out  1  one-cycle pulse: binary_out advanced by exactly one (incl. wrap)
wrap  out  1  one-cycle pulse: binary_out went MAX_COUNT→0 (step also high)
err  out  1  sticky flag: illegal transition observed

Behaviour:
- Reset (reset_n=0 at rising clk): all sync stages, binary_out, prev value, fill counter → 0; valid=0, step=0, wrap=0, err=0. Reset mid-operation behaves identically and discards the pipeline contents.
- Synchronizer: gray_in → stage[0] → … → stage[SYNC_STAGES-1]; one flop per stage, no logic between stages.
- Decode: bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1]^g[i]. Combinational on the last stage, then registered into binary_out.
- Latency: a gray_in change is stable before edge k; binary_out shows it after edge k+SYNC_STAGES.
- valid: a fill counter runs after reset release. valid goes 1 on the (SYNC_STAGES+1)th edge with reset_n=1 and stays 1 until the next reset. While valid=0, step/wrap/err are not evaluated.
- Transition check, every edge with valid=1; new = decoded value, old = current binary_out:
  new==old → no strobe.
  old<MAX_COUNT and new==old+1 → step=1.
  old==MAX_COUNT and new==0 → step=1, wrap=1. This is legal even when the Gray Hamming distance is >1, as happens for non-power-of-2 MAX_COUNT.
  any other case → err set. binary_out still updates to new, so tracking resynchronizes.
  new>MAX_COUNT → always err.
- step and wrap are single-cycle pulses. Consecutive +1 steps on consecutive edges give step high on each edge.
- err is sticky. err_clr=1 clears it on the next edge. If err_clr and a new illegal transition occur on the same edge, err stays 1 (set wins).
- binary_out always follows the decode once valid, whether or not the transition was illegal.

Optional Feature:
GRAY_SYNC_ERRCNT_EN
- Defined: adds output err_count [7:0]. It increments on each illegal transition, saturates at 255, and is cleared by reset or err_clr. If err_clr and an illegal transition occur on the same edge, the counter is loaded with 1.
- Undefined: the port and the counter are absent. err behaviour is unchanged.

Decomposition:
- Package gray_pkg:
  gray2bin and bin2gray functions, parameterized on width;
  localparam defaults for WIDTH=4 and MAX_COUNT=15, shared with the counter.
- Sub-module sync_chain: generic N-stage, W-bit flop synchronizer with synchronous active-low reset. It is instantiated once here and is reusable for other CDC points.
- Transition check and strobes stay in gray_sync_decoder.

Test Plan:
- Reset/fill, SYNC_STAGES=2: reset_n low for 3 edges, then high with gray_in=0 → valid=0 for 2 edges, valid=1 on 3rd edge; binary_out=0; step/wrap/err=0.
- Full count sweep: feed Gray 0→15 (0,1,3,2,6,…,8), one change per 4 clk → binary_out 0..15 in order, 15 step pulses, no err. Each value appears 2 edges after its change.
- Wrap: MAX_COUNT=9, gray_in 13 (bin 9) → 0 (Hamming 3) → step=1, wrap=1, err=0.
- Illegal jump: binary_out=3, gray_in driven to gray(7)=4 → err=1 sticky, binary_out=7, step=0. Hold err_clr=1 for one edge → err=0.
- Simultaneous clear and error: err=1, err_clr=1 on the same edge as a new jump 7→2 → err stays 1. With GRAY_SYNC_ERRCNT_EN, err_count=1.
- Reset mid-sweep at binary_out=6: reset_n low 1 edge → all outputs 0, valid drops, and re-asserts after SYNC_STAGES+1 edges with no spurious err on the first compare.
